// File: rtl/uart_send_fifo.sv
// Queued UART transmitter: start, LSB-first data, optional parity, 1-2 stop cells.
// Define UART_SEND_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line idle, waiting for a queued byte
// ST_START  | start cell (line low)
// ST_DATA   | data cells, LSB first
// ST_PARITY | parity cell (only when PARITY != 0)
// ST_STOP   | stop cell(s), line high
module uart_send_fifo #(
  parameter int WAIT_CYCLES = 10,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          transmitByte,
  output logic                          ready,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          uart_tx
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(WAIT_CYCLES);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic                 push;
  logic                 pop;
  logic                 q_full;
  logic                 q_empty;
  logic [DATA_BITS-1:0] q_data;
  logic [LW-1:0]        q_count;

  assign push = transmitByte && !q_full;

`ifdef UART_SEND_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        count;

  // Pointers are exactly AW bits wide, so they wrap at FIFO_DEPTH by themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  assign q_data  = mem[rd_ptr];
  assign q_count = count;
  assign q_full  = (count == LW'(FIFO_DEPTH));
  assign q_empty = (count == '0);
`else
  logic [DATA_BITS-1:0] hold;
  logic                 hold_vld;

  // push needs !full and pop needs !empty, so they never coincide here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold     <= '0;
      hold_vld <= 1'b0;
    end else if (push) begin
      hold     <= data;
      hold_vld <= 1'b1;
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end

  assign q_data  = hold;
  assign q_count = LW'(hold_vld);
  assign q_full  = hold_vld;
  assign q_empty = !hold_vld;
`endif

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cell_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 line_nxt;
  logic                 line_active;
  logic                 cell_end;
  logic                 last_data;
  logic                 last_stop;

  assign cell_end  = (cell_cnt == '0);
  assign last_data = (bit_idx == BW'(DATA_BITS - 1));
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    line_nxt  = 1'b1;
    case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          state_nxt = ST_START;
          pop       = 1'b1;
        end
      end
      ST_START: begin
        line_nxt = 1'b0;
        if (cell_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        line_nxt = shreg[0];
        if (cell_end && last_data) state_nxt = (PARITY != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        line_nxt = par_bit;
        if (cell_end) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (cell_end && last_stop) begin
          if (!q_empty) begin
            state_nxt = ST_START;
            pop       = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // uart_tx is the registered image of the current state's cell, one clock behind the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cell_cnt    <= CW'(WAIT_CYCLES - 1);
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      uart_tx     <= 1'b1;
      line_active <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      uart_tx     <= line_nxt;
      line_active <= (state != ST_IDLE);
      if (transmitByte && q_full) overflow <= 1'b1;

      if (state == ST_IDLE || cell_end) cell_cnt <= CW'(WAIT_CYCLES - 1);
      else                              cell_cnt <= cell_cnt - CW'(1);

      if (state != ST_DATA) begin
        bit_idx <= '0;
      end else if (cell_end) begin
        bit_idx <= bit_idx + BW'(1);
        shreg   <= shreg >> 1;
      end

      if (state != ST_STOP)  stop_idx <= 1'b0;
      else if (cell_end)     stop_idx <= !stop_idx;

      if (pop) begin
        shreg   <= q_data;
        par_bit <= (^q_data) ^ (PARITY == 1);
      end
    end
  end

  assign ready = !q_full;
  assign busy  = (state != ST_IDLE) || !q_empty || line_active;
  assign level = q_count;

endmodule

// File: tb/tb_uart_send_fifo.sv
// Bench for uart_send_fifo: four parameterisations checked every cycle against a
// frame-timeline model, plus hand-computed literal expectations.
module tb_uart_send_fifo;

  localparam int W  = 4;
  localparam int NI = 4;
`ifdef UART_SEND_FIFO_EN
  localparam int QD = 4;
`else
  localparam int QD = 1;
`endif
  localparam int DBA [NI] = '{8, 8, 8, 7};
  localparam int PARA[NI] = '{0, 2, 1, 0};
  localparam int STA [NI] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] d   [NI];
  logic       wr  [NI];
  logic       rdy [NI];
  logic       bsy [NI];
  logic       ovf [NI];
  logic       tx  [NI];
  logic [2:0] lvl [NI];

  always #5 clk = ~clk;

  uart_send_fifo #(.WAIT_CYCLES(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .data(d[0][7:0]), .transmitByte(wr[0]), .ready(rdy[0]),
    .busy(bsy[0]), .overflow(ovf[0]), .level(lvl[0]), .uart_tx(tx[0]));
  uart_send_fifo #(.WAIT_CYCLES(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .data(d[1][7:0]), .transmitByte(wr[1]), .ready(rdy[1]),
    .busy(bsy[1]), .overflow(ovf[1]), .level(lvl[1]), .uart_tx(tx[1]));
  uart_send_fifo #(.WAIT_CYCLES(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .data(d[2][7:0]), .transmitByte(wr[2]), .ready(rdy[2]),
    .busy(bsy[2]), .overflow(ovf[2]), .level(lvl[2]), .uart_tx(tx[2]));
  uart_send_fifo #(.WAIT_CYCLES(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst_n(rst_n), .data(d[3][6:0]), .transmitByte(wr[3]), .ready(rdy[3]),
    .busy(bsy[3]), .overflow(ovf[3]), .level(lvl[3]), .uart_tx(tx[3]));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // Model: each dequeued byte owns the line for flen clocks starting the clock after its
  // dequeue edge; the next dequeue may happen no earlier than dequeue + flen.
  logic [8:0] mq [NI][$];
  bit         has_cur [NI];
  bit         has_prev[NI];
  int         cur_d   [NI];
  int         prev_d  [NI];
  logic [8:0] cur_v   [NI];
  logic [8:0] prev_v  [NI];
  bit         m_ovf   [NI];

  function automatic int flen(int i);
    return (1 + DBA[i] + ((PARA[i] != 0) ? 1 : 0) + STA[i]) * W;
  endfunction

  function automatic logic cell_val(int i, logic [8:0] v, int c);
    logic p;
    if (c == 0) return 1'b0;
    if (c <= DBA[i]) return v[c-1];
    if (PARA[i] != 0 && c == DBA[i] + 1) begin
      p = 1'b0;
      for (int j = 0; j < DBA[i]; j++) p = p ^ v[j];
      return (PARA[i] == 1) ? ~p : p;
    end
    return 1'b1;
  endfunction

  function automatic logic exp_line(int i);
    int t = cyc - 1;
    if (has_cur[i] && t >= cur_d[i] && t < cur_d[i] + flen(i))
      return cell_val(i, cur_v[i], (t - cur_d[i]) / W);
    if (has_prev[i] && t >= prev_d[i] && t < prev_d[i] + flen(i))
      return cell_val(i, prev_v[i], (t - prev_d[i]) / W);
    return 1'b1;
  endfunction

  function automatic logic exp_busy(int i);
    if (mq[i].size() > 0) return 1'b1;
    if (has_cur[i] && cyc >= cur_d[i] && cyc <= cur_d[i] + flen(i)) return 1'b1;
    if (has_prev[i] && cyc >= prev_d[i] && cyc <= prev_d[i] + flen(i)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset(int i);
    mq[i].delete();
    has_cur[i]  = 1'b0;
    has_prev[i] = 1'b0;
    m_ovf[i]    = 1'b0;
  endtask

  task automatic m_step(int i);
    int pre = mq[i].size();
    logic [8:0] msk = (9'h001 << DBA[i]) - 9'h001;
    if (pre > 0 && !(has_cur[i] && cyc < cur_d[i] + flen(i))) begin
      has_prev[i] = has_cur[i];
      prev_d[i]   = cur_d[i];
      prev_v[i]   = cur_v[i];
      has_cur[i]  = 1'b1;
      cur_d[i]    = cyc;
      cur_v[i]    = mq[i].pop_front();
    end
    if (wr[i]) begin
      if (pre < QD) mq[i].push_back(d[i] & msk);
      else          m_ovf[i] = 1'b1;
    end
  endtask

  // Inputs only change 1 time unit after a falling edge, so here they still hold the
  // values the DUT sampled at the preceding rising edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) m_reset(i);
      else        m_step(i);
      chk($sformatf("tx[%0d]", i),    int'(tx[i]),  int'(exp_line(i)));
      chk($sformatf("level[%0d]", i), int'(lvl[i]), mq[i].size());
      chk($sformatf("ready[%0d]", i), int'(rdy[i]), (mq[i].size() < QD) ? 1 : 0);
      chk($sformatf("busy[%0d]", i),  int'(bsy[i]), int'(exp_busy(i)));
      chk($sformatf("ovf[%0d]", i),   int'(ovf[i]), int'(m_ovf[i]));
    end
  end

  task automatic wait_to(int t);
    while (cyc < t) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(int i);
    int n = 0;
    while (!rdy[i] && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rdy[i]) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout[%0d] t=%0d actual=0 expected=1", i, cyc);
    end
  endtask

  task automatic wait_idle(int i);
    int n = 0;
    while (bsy[i] && n < 600) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (bsy[i]) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout[%0d] t=%0d actual=1 expected=0", i, cyc);
    end
  endtask

  // Returns the edge index k at which the byte was accepted; data is scrambled afterwards.
  task automatic send(int i, logic [8:0] v, output int k);
    wait_ready(i);
    d[i]  = v;
    wr[i] = 1'b1;
    @(negedge clk);
    #1;
    k     = cyc;
    wr[i] = 1'b0;
    d[i]  = ~v;
  endtask

  int         k;
  int         kd;
  logic [9:0] exp_a5;
  int         cl[5];
  int         cr[5];
  int         co[5];
  logic [8:0] burst[5];

  initial begin
    for (int i = 0; i < NI; i++) begin
      d[i]  = '0;
      wr[i] = 1'b0;
    end
    exp_a5   = 10'b1101001010;
    burst[0] = 9'h022; burst[1] = 9'h033; burst[2] = 9'h044; burst[3] = 9'h055; burst[4] = 9'h066;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", int'(tx[0]), 1);
    chk("rst_ready", int'(rdy[0]), 1);
    chk("rst_busy", int'(bsy[0]), 0);
    chk("rst_ovf", int'(ovf[0]), 0);
    chk("rst_level", int'(lvl[0]), 0);
    rst_n = 1'b1;
    wait_to(cyc + 2);

    // 8N1 0xA5 on u0, even/odd parity 0x07 on u1/u2, all written on the same edge
    d[0] = 9'h0A5; d[1] = 9'h007; d[2] = 9'h007;
    wr[0] = 1'b1; wr[1] = 1'b1; wr[2] = 1'b1;
    @(negedge clk);
    #1;
    k = cyc;
    wr[0] = 1'b0; wr[1] = 1'b0; wr[2] = 1'b0;
    d[0] = 9'h15A; d[1] = 9'h1F8; d[2] = 9'h1F8;
    chk("a5_level_k", int'(lvl[0]), 1);
    wait_to(k + 1);
    chk("a5_idle_k1", int'(tx[0]), 1);
    wait_to(k + 2);
    chk("a5_start_k2", int'(tx[0]), 0);
    for (int c = 0; c < 10; c++) begin
      wait_to(k + 3 + 4 * c);
      chk($sformatf("a5_cell%0d", c), int'(tx[0]), int'(exp_a5[c]));
    end
    chk("even_par_07", int'(tx[1]), 1);
    chk("odd_par_07", int'(tx[2]), 0);
    wait_to(k + 41);
    chk("a5_busy_k41", int'(bsy[0]), 1);
    wait_to(k + 42);
    chk("a5_busy_k42", int'(bsy[0]), 0);
    wait_idle(1);
    wait_idle(2);

    // 7 data bits, 2 stop bits, three frames back to back on u3
    send(3, 9'h041, k);
    send(3, 9'h042, kd);
    send(3, 9'h043, kd);
    wait_to(k + 81);
    chk("b2b_f2_stop", int'(tx[3]), 1);
    wait_to(k + 82);
    chk("b2b_f3_start", int'(tx[3]), 0);
    wait_to(k + 121);
    chk("b2b_busy_last", int'(bsy[3]), 1);
    wait_to(k + 122);
    chk("b2b_busy_after", int'(bsy[3]), 0);
    chk("b2b_tx_after", int'(tx[3]), 1);

    // five writes while a frame is in flight on u0
    send(0, 9'h011, k);
    wait_to(k + 3);
    for (int j = 0; j < 5; j++) begin
      d[0]  = burst[j];
      wr[0] = 1'b1;
      @(negedge clk);
      #1;
      cl[j] = int'(lvl[0]);
      cr[j] = int'(rdy[0]);
      co[j] = int'(ovf[0]);
    end
    wr[0] = 1'b0;
    d[0]  = 9'h1FF;
`ifdef UART_SEND_FIFO_EN
    chk("burst_level_4th", cl[3], 4);
    chk("burst_ready_4th", cr[3], 0);
    chk("burst_ovf_4th", co[3], 0);
    chk("burst_level_5th", cl[4], 4);
    chk("burst_ovf_5th", co[4], 1);
`else
    chk("hold_level_2nd", cl[0], 1);
    chk("hold_ready_2nd", cr[0], 0);
    chk("hold_ovf_2nd", co[0], 0);
    chk("hold_ovf_3rd", co[1], 1);
    chk("hold_level_end", cl[4], 1);
`endif
    wait_idle(0);

    // reset pulse during data bit 3 of 0x35 with another byte queued
    send(0, 9'h035, k);
    wait_to(k + 3);
    d[0]  = 9'h099;
    wr[0] = 1'b1;
    @(negedge clk);
    #1;
    wr[0] = 1'b0;
    wait_to(k + 19);
    chk("pre_rst_bit3", int'(tx[0]), 0);
    chk("pre_rst_level", int'(lvl[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", int'(tx[0]), 1);
    chk("async_rst_level", int'(lvl[0]), 0);
    chk("async_rst_ready", int'(rdy[0]), 1);
    chk("async_rst_busy", int'(bsy[0]), 0);
    chk("async_rst_ovf", int'(ovf[0]), 0);
    wait_to(cyc + 2);
    rst_n = 1'b1;
    wait_to(cyc + 2);
    chk("post_rst_idle", int'(tx[0]), 1);
    send(0, 9'h05A, k);
    wait_to(k + 1);
    chk("post_rst_k1", int'(tx[0]), 1);
    wait_to(k + 2);
    chk("post_rst_k2", int'(tx[0]), 0);
    wait_idle(0);
    wait_to(cyc + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_send_fifo.md
UART_SEND_FIFO -- requirements
Module: uart_send_fifo

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 10, meaning clocks per bit cell (legal range 2..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal range 5..9).
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop cells per frame (legal values 1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, meaning entries per FIFO (power of two, range 2..256).
REQ-006 SHALL have port clk, input, 1 bit, meaning the single clock; all logic on posedge.
REQ-007 SHALL have port rst_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-008 SHALL have port data, input, DATA_BITS bits, meaning the payload to queue.
REQ-009 SHALL have port transmitByte, input, 1 bit, meaning the write strobe; data is accepted on a clock edge where transmitByte and ready are both high.
REQ-010 SHALL have port ready, output, 1 bit, meaning space available (not full).
REQ-011 SHALL have port busy, output, 1 bit, meaning a frame is on the line or the queue is not empty.
REQ-012 SHALL have port overflow, output, 1 bit, meaning sticky: a write was attempted while full.
REQ-013 SHALL have port level, output, $clog2(FIFO_DEPTH)+1 bits, meaning the number of queued entries, excluding the frame in flight.
REQ-014 SHALL have port uart_tx, output, 1 bit, meaning the registered serial line, idle high.

Function
REQ-015 Frame SHALL be sent in this order: start (0), data LSB first, optional parity, then STOP_BITS stop cells (1); each cell lasts exactly WAIT_CYCLES clocks.
REQ-016 Parity bit SHALL be the XOR of the data bits for even parity and its inverse for odd parity.
REQ-017 States SHALL be IDLE, START, DATA, PARITY, STOP, with IDLE->START on non-empty, START->DATA, DATA->PARITY (PARITY!=0) or DATA->STOP after bit DATA_BITS-1, PARITY->STOP, STOP->START if non-empty else IDLE; each transition occurs only at the end of a cell.
REQ-018 Latency SHALL be such that a write accepted at edge k into an empty, idle block drives uart_tx low from edge k+2.
REQ-019 Back-to-back frames SHALL have zero idle gap: the next start cell begins on the clock after the last stop cell ends.
REQ-020 Dequeue SHALL occur on the transition into START; level SHALL decrement on that same edge.
REQ-021 Simultaneous write and dequeue SHALL leave level unchanged and lose no data, including when full: ready is low when full, so no write is accepted that cycle.
REQ-022 A write while full SHALL be dropped, leave FIFO contents unchanged, and set overflow.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH, and level SHALL distinguish full (FIFO_DEPTH) from empty (0).
REQ-024 The cell counter SHALL restart at each cell boundary, with no cumulative drift across frames.
REQ-025 Changes to data while a frame is in flight SHALL have no effect on that frame.

Reset
REQ-026 Asserting rst_n low SHALL immediately force uart_tx=1, ready=1, busy=0, overflow=0, level=0 and state IDLE, and SHALL empty the FIFO pointers.
REQ-027 Reset mid-frame SHALL abort the frame, with the line high within the assertion and no partial frame resumed after release.
REQ-028 After deassertion the first accepted write SHALL obey REQ-018.

Configuration
REQ-029 When UART_SEND_FIFO_EN is defined, the queue SHALL be a FIFO_DEPTH-entry FIFO per REQ-020..REQ-023.
REQ-030 When UART_SEND_FIFO_EN is undefined, the queue SHALL be a single holding register (effective depth 1), FIFO_DEPTH SHALL be ignored, level SHALL be 0 or 1, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Bench SHALL cover: WAIT_CYCLES=4, DATA_BITS=8, PARITY=0, write 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each cell 4 clocks, start low at k+2, 40 clocks total.
REQ-032 Bench SHALL cover: PARITY=2, write 0x07 -> parity cell 1; PARITY=1, write 0x07 -> parity cell 0.
REQ-033 Bench SHALL cover: STOP_BITS=2, DATA_BITS=7, three consecutive writes 0x41, 0x42, 0x43 -> three contiguous 40-clock frames (WAIT_CYCLES=4), no gaps, busy low 1 clock after the final stop.
REQ-034 Bench SHALL cover: FIFO_DEPTH=4, five writes while a frame is in flight -> ready low after the 4th, 5th dropped, overflow=1, level=4, transmitted sequence intact.
REQ-035 Bench SHALL cover: rst_n pulsed low during data bit 3 -> uart_tx=1 asynchronously, level=0, next write frames correctly.
REQ-036 Bench SHALL cover: UART_SEND_FIFO_EN undefined, second write during a frame accepted and third write dropped with overflow=1.
